// File: rtl/timer_seq_pkg.sv
// Shared types and defaults for the timer APB sequencer.
// Build option TIMER_SEQ_READBACK_EN adds TDR/TCR readback steps.
package timer_seq_pkg;

  localparam logic [7:0] DEF_ADDR_TCR      = 8'h00;
  localparam logic [7:0] DEF_ADDR_TDR      = 8'h01;
  localparam logic [7:0] DEF_ADDR_TSR      = 8'h02;
  localparam logic [7:0] DEF_TCR_LOAD_MASK = 8'h80;
  localparam logic [7:0] DEF_TSR_CLR_VALUE = 8'h00;

`ifdef TIMER_SEQ_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    X_IDLE,
    X_SETUP,
    X_ACCESS
  } xfer_state_t;

  typedef enum logic {
    T_IDLE,
    T_RUN
  } seq_state_t;

  typedef enum logic [2:0] {
    W_TDR,
    W_TCR_LD,
    W_TCR,
    R_TDR,
    R_TCR,
    R_TSR,
    W_TSR,
    S_END
  } step_t;

  localparam step_t CMD_FIRST = W_TDR;
  localparam step_t SVC_FIRST = R_TSR;

  // S_END terminates both the command and the service list
  function automatic step_t next_step(input step_t s);
    step_t n;
    n = S_END;
    case (s)
      W_TDR:    n = RB_EN ? R_TDR : W_TCR_LD;
      R_TDR:    n = W_TCR_LD;
      W_TCR_LD: n = W_TCR;
      W_TCR:    n = RB_EN ? R_TCR : S_END;
      R_TSR:    n = W_TSR;
      default:  n = S_END;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/timer_apb_sequencer_xfer.sv
// APB SETUP/ACCESS engine; a req on the completing
// ACCESS chains straight into the next SETUP.
module apb_xfer_engine
  import timer_seq_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          write,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          slverr,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  xfer_state_t state;

  assign done   = (state == X_ACCESS) & pready;
  assign rdata  = prdata;
  assign slverr = pslverr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= X_IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      unique case (state)
        X_IDLE: begin
          if (req) begin
            state  <= X_SETUP;
            psel   <= 1'b1;
            pwrite <= write;
            paddr  <= addr;
            pwdata <= wdata;
          end
        end
        X_SETUP: begin
          state   <= X_ACCESS;
          penable <= 1'b1;
        end
        X_ACCESS: begin
          if (pready) begin
            penable <= 1'b0;
            if (req) begin
              state  <= X_SETUP;
              pwrite <= write;
              paddr  <= addr;
              pwdata <= wdata;
            end else begin
              state <= X_IDLE;
              psel  <= 1'b0;
            end
          end
        end
        default: state <= X_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/timer_apb_sequencer.sv
// Timer command/service sequencer over APB.
// TIMER_SEQ_READBACK_EN: verify TDR/TCR by readback.
module timer_apb_sequencer
  import timer_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDR_TCR = DEF_ADDR_TCR,
  parameter logic [ADDR_WIDTH-1:0] ADDR_TDR = DEF_ADDR_TDR,
  parameter logic [ADDR_WIDTH-1:0] ADDR_TSR = DEF_ADDR_TSR,
  parameter logic [DATA_WIDTH-1:0] TCR_LOAD_MASK = DEF_TCR_LOAD_MASK,
  parameter logic [DATA_WIDTH-1:0] TSR_CLR_VALUE = DEF_TSR_CLR_VALUE
) (
  input  logic                  PCLK,
  input  logic                  PRESET_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_tdr,
  input  logic [DATA_WIDTH-1:0] cmd_tcr,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] tsr_value,
  output logic [7:0]            ovf_cnt,
  output logic [7:0]            udf_cnt,
  input  logic                  tmr_ovf,
  input  logic                  tmr_urf,
  output logic                  m_psel,
  output logic                  m_penable,
  output logic                  m_pwrite,
  output logic [ADDR_WIDTH-1:0] m_paddr,
  output logic [DATA_WIDTH-1:0] m_pwdata,
  input  logic [DATA_WIDTH-1:0] m_prdata,
  input  logic                  m_pready,
  input  logic                  m_pslverr
);

  seq_state_t            state;
  step_t                 step;
  step_t                 nxt;
  step_t                 req_step;
  logic [DATA_WIDTH-1:0] tdr_q;
  logic [DATA_WIDTH-1:0] tcr_q;
  logic [DATA_WIDTH-1:0] src_tdr;
  logic                  pend_ovf;
  logic                  pend_udf;
  logic                  rdy_q;
  logic                  start_svc;
  logic                  start_cmd;
  logic                  req;
  logic                  last;
  logic                  rb_bad;
  logic                  fail;
  logic                  x_done;
  logic                  x_err;
  logic [DATA_WIDTH-1:0] x_rdata;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_write;

  // rdy_q keeps cmd_ready low while reset is held
  assign cmd_ready = rdy_q & (state == T_IDLE)
                   & ~pend_ovf & ~pend_udf;
  assign start_svc = rdy_q & (state == T_IDLE)
                   & (pend_ovf | pend_udf);
  assign start_cmd = cmd_valid & cmd_ready;

  assign nxt    = next_step(step);
  assign last   = (nxt == S_END);
  assign rb_bad = ((step == R_TDR) && (x_rdata != tdr_q))
               || ((step == R_TCR) && (x_rdata != tcr_q));
  assign fail   = x_done & (x_err | rb_bad);
  assign req    = start_svc | start_cmd
               | ((state == T_RUN) & x_done & ~fail & ~last);
  assign src_tdr = start_cmd ? cmd_tdr : tdr_q;

  always_comb begin
    req_step = nxt;
    unique case (1'b1)
      start_svc: req_step = SVC_FIRST;
      start_cmd: req_step = CMD_FIRST;
      default:   req_step = nxt;
    endcase
  end

  always_comb begin
    req_addr  = ADDR_TCR;
    req_wdata = tcr_q;
    req_write = 1'b1;
    case (req_step)
      W_TDR: begin
        req_addr  = ADDR_TDR;
        req_wdata = src_tdr;
      end
      W_TCR_LD: req_wdata = tcr_q | TCR_LOAD_MASK;
      R_TDR: begin
        req_addr  = ADDR_TDR;
        req_write = 1'b0;
      end
      R_TCR: req_write = 1'b0;
      R_TSR: begin
        req_addr  = ADDR_TSR;
        req_write = 1'b0;
      end
      W_TSR: begin
        req_addr  = ADDR_TSR;
        req_wdata = TSR_CLR_VALUE;
      end
      default: ;
    endcase
  end

  apb_xfer_engine #(
    .AW (ADDR_WIDTH),
    .DW (DATA_WIDTH)
  ) u_xfer (
    .clk     (PCLK),
    .rst_n   (PRESET_n),
    .req     (req),
    .addr    (req_addr),
    .wdata   (req_wdata),
    .write   (req_write),
    .done    (x_done),
    .rdata   (x_rdata),
    .slverr  (x_err),
    .psel    (m_psel),
    .penable (m_penable),
    .pwrite  (m_pwrite),
    .paddr   (m_paddr),
    .pwdata  (m_pwdata),
    .prdata  (m_prdata),
    .pready  (m_pready),
    .pslverr (m_pslverr)
  );

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state     <= T_IDLE;
      step      <= S_END;
      tdr_q     <= '0;
      tcr_q     <= '0;
      pend_ovf  <= 1'b0;
      pend_udf  <= 1'b0;
      rdy_q     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      tsr_value <= '0;
      ovf_cnt   <= 8'h00;
      udf_cnt   <= 8'h00;
    end else begin
      rdy_q <= 1'b1;
      done  <= 1'b0;
      err   <= 1'b0;
      // a pulse coinciding with service start re-arms the flag
      pend_ovf <= (pend_ovf & ~start_svc) | tmr_ovf;
      pend_udf <= (pend_udf & ~start_svc) | tmr_urf;
      if (tmr_ovf && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      if (tmr_urf && udf_cnt != 8'hFF) udf_cnt <= udf_cnt + 8'd1;
      unique case (state)
        T_IDLE: begin
          if (start_svc || start_cmd) begin
            state <= T_RUN;
            step  <= req_step;
          end
          if (start_cmd) begin
            tdr_q <= cmd_tdr;
            tcr_q <= cmd_tcr;
          end
        end
        T_RUN: begin
          if (x_done) begin
            if (step == R_TSR) tsr_value <= x_rdata;
            if (fail) begin
              err   <= 1'b1;
              state <= T_IDLE;
            end else if (last) begin
              done  <= (step != W_TSR);
              state <= T_IDLE;
            end else begin
              step <= req_step;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_apb_sequencer.sv
// Randomized bench for timer_apb_sequencer: a cycle timeline
// model predicts every APB phase, pulse and counter.
`timescale 1ns/1ps
module tb_timer_apb_sequencer;

  logic       PCLK = 1'b0;
  logic       PRESET_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_tdr = 8'h00;
  logic [7:0] cmd_tcr = 8'h00;
  logic       done;
  logic       err;
  logic [7:0] tsr_value;
  logic [7:0] ovf_cnt;
  logic [7:0] udf_cnt;
  logic       tmr_ovf = 1'b0;
  logic       tmr_urf = 1'b0;
  logic       m_psel;
  logic       m_penable;
  logic       m_pwrite;
  logic [7:0] m_paddr;
  logic [7:0] m_pwdata;
  logic [7:0] m_prdata = 8'h00;
  logic       m_pready = 1'b0;
  logic       m_pslverr = 1'b0;

  timer_apb_sequencer dut (
    .PCLK      (PCLK),
    .PRESET_n  (PRESET_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_tdr   (cmd_tdr),
    .cmd_tcr   (cmd_tcr),
    .done      (done),
    .err       (err),
    .tsr_value (tsr_value),
    .ovf_cnt   (ovf_cnt),
    .udf_cnt   (udf_cnt),
    .tmr_ovf   (tmr_ovf),
    .tmr_urf   (tmr_urf),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pwrite  (m_pwrite),
    .m_paddr   (m_paddr),
    .m_pwdata  (m_pwdata),
    .m_prdata  (m_prdata),
    .m_pready  (m_pready),
    .m_pslverr (m_pslverr)
  );

  always #5 PCLK = ~PCLK;

`ifdef TIMER_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct packed {
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic       pready;
    logic [7:0] prdata;
    logic       pslverr;
    logic       upd_tsr;
    logic       fin_done;
    logic       fin_err;
  } ent_t;

  typedef struct {
    bit       wr;
    bit [7:0] addr;
    bit [7:0] data;
    bit       tsr_rd;
    bit       rb;
  } stp_t;

  typedef struct {
    bit       wr;
    bit [7:0] addr;
    bit [7:0] data;
  } obs_t;

  ent_t q[$];
  obs_t obs[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bit       mdl_pend_o, mdl_pend_u, mdl_done, mdl_err;
  bit [7:0] mdl_tsr, mdl_ovf, mdl_udf;

  bit       rnd = 1'b0;
  int       wait_fix = 0;
  int       wait_max = 2;
  int       err_pct = 0;
  int       err_idx = -1;
  int       rbm_pct = 0;
  bit       rb_zero_tdr = 1'b0;
  int       evt_pct = 0;
  int       vld_pct = 0;
  int       tsr_fix = -1;
  bit       drv_valid = 1'b0;
  bit [7:0] drv_tdr = 8'h00;
  bit [7:0] drv_tcr = 8'h00;
  bit       drv_ovf = 1'b0;
  bit       drv_urf = 1'b0;

  int       acc_n = 0;
  int       acc_cyc = 0;
  int       done_cyc = 0;
  int       done_seen = 0;
  int       err_seen = 0;
  bit       smp_ready;
  bit [7:0] smp_tsr, smp_udf;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h",
               name, cyc, act, exp);
    end
  endtask

  task automatic build(bit svc, bit [7:0] tdr, bit [7:0] tcr);
    stp_t s[$];
    if (svc) begin
      s.push_back('{1'b0, 8'h02, 8'h00, 1'b1, 1'b0});
      s.push_back('{1'b1, 8'h02, 8'h00, 1'b0, 1'b0});
    end else begin
      s.push_back('{1'b1, 8'h01, tdr, 1'b0, 1'b0});
      if (RB) s.push_back('{1'b0, 8'h01, tdr, 1'b0, 1'b1});
      s.push_back('{1'b1, 8'h00, tcr | 8'h80, 1'b0, 1'b0});
      s.push_back('{1'b1, 8'h00, tcr, 1'b0, 1'b0});
      if (RB) s.push_back('{1'b0, 8'h00, tcr, 1'b0, 1'b1});
    end
    foreach (s[i]) begin
      int       w;
      bit       e;
      bit       bad;
      bit [7:0] rd;
      ent_t     en;
      w = (wait_fix >= 0) ? wait_fix : $urandom_range(0, wait_max);
      e = (!svc && i == err_idx) || ($urandom_range(0, 99) < err_pct);
      rd = 8'($urandom);
      if (s[i].tsr_rd && tsr_fix >= 0) rd = tsr_fix[7:0];
      if (s[i].rb) begin
        rd = s[i].data;
        if (rb_zero_tdr && s[i].addr == 8'h01) rd = 8'h00;
        else if ($urandom_range(0, 99) < rbm_pct) rd = s[i].data ^ 8'h10;
      end
      bad = e || (s[i].rb && rd != s[i].data);
      en = '0;
      en.psel = 1'b1;
      en.pwrite = s[i].wr;
      en.paddr = s[i].addr;
      en.pwdata = s[i].data;
      q.push_back(en);
      en.penable = 1'b1;
      repeat (w) begin
        en.prdata = 8'($urandom);
        en.pslverr = 1'($urandom_range(0, 1));
        q.push_back(en);
      end
      en.pready = 1'b1;
      en.prdata = rd;
      en.pslverr = e;
      en.upd_tsr = s[i].tsr_rd;
      en.fin_err = bad;
      en.fin_done = !bad && !svc && (i == s.size() - 1);
      q.push_back(en);
      if (bad) break;
    end
  endtask

  task automatic tick();
    ent_t cur;
    bit   idle, svc, cmd, nd, ne;
    @(negedge PCLK);
    cyc++;
    cur = '0;
    if (q.size() > 0) cur = q[0];
    chk("psel", m_psel, cur.psel);
    chk("penable", m_penable, cur.penable);
    if (cur.psel) begin
      chk("paddr", m_paddr, cur.paddr);
      chk("pwrite", m_pwrite, cur.pwrite);
      if (cur.pwrite) chk("pwdata", m_pwdata, cur.pwdata);
    end
    chk("done", done, mdl_done);
    chk("err", err, mdl_err);
    chk("cmd_ready", cmd_ready,
        q.size() == 0 && !mdl_pend_o && !mdl_pend_u);
    chk("tsr_value", tsr_value, mdl_tsr);
    chk("ovf_cnt", ovf_cnt, mdl_ovf);
    chk("udf_cnt", udf_cnt, mdl_udf);
    smp_ready = cmd_ready;
    smp_tsr = tsr_value;
    smp_udf = udf_cnt;
    if (done) begin
      done_seen++;
      done_cyc = cyc;
    end
    if (err) err_seen++;
    if (cur.psel && cur.penable && cur.pready)
      obs.push_back('{m_pwrite, m_paddr, m_pwdata});
    m_pready = cur.pready;
    m_prdata = cur.penable ? cur.prdata : 8'($urandom);
    m_pslverr = cur.penable ? cur.pslverr : 1'b0;
    if (rnd) begin
      cmd_valid = ($urandom_range(0, 99) < vld_pct);
      cmd_tdr = 8'($urandom);
      cmd_tcr = 8'($urandom);
      tmr_ovf = ($urandom_range(0, 99) < evt_pct);
      tmr_urf = ($urandom_range(0, 99) < evt_pct);
    end else begin
      cmd_valid = drv_valid;
      cmd_tdr = drv_tdr;
      cmd_tcr = drv_tcr;
      tmr_ovf = drv_ovf;
      tmr_urf = drv_urf;
    end
    nd = cur.fin_done;
    ne = cur.fin_err;
    if (cur.upd_tsr) mdl_tsr = cur.prdata;
    idle = (q.size() == 0);
    svc = idle && (mdl_pend_o || mdl_pend_u);
    cmd = idle && !svc && cmd_valid;
    if (!idle) q.delete(0);
    mdl_pend_o = (mdl_pend_o && !svc) || tmr_ovf;
    mdl_pend_u = (mdl_pend_u && !svc) || tmr_urf;
    if (tmr_ovf && mdl_ovf != 8'hFF) mdl_ovf++;
    if (tmr_urf && mdl_udf != 8'hFF) mdl_udf++;
    if (svc) build(1'b1, 8'h00, 8'h00);
    if (cmd) begin
      build(1'b0, cmd_tdr, cmd_tcr);
      acc_n++;
      acc_cyc = cyc;
    end
    mdl_done = nd;
    mdl_err = ne;
    @(posedge PCLK);
  endtask

  task automatic do_reset();
    PRESET_n = 1'b0;
    cmd_valid = 1'b0;
    tmr_ovf = 1'b0;
    tmr_urf = 1'b0;
    m_pready = 1'b0;
    m_pslverr = 1'b0;
    m_prdata = 8'h00;
    q.delete();
    mdl_pend_o = 0;
    mdl_pend_u = 0;
    mdl_done = 0;
    mdl_err = 0;
    mdl_tsr = 0;
    mdl_ovf = 0;
    mdl_udf = 0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESET_n = 1'b1;
    @(posedge PCLK);
  endtask

  task automatic run_cmd(bit [7:0] tdr, bit [7:0] tcr);
    int n0, k;
    n0 = acc_n;
    drv_valid = 1'b1;
    drv_tdr = tdr;
    drv_tcr = tcr;
    k = 0;
    while (acc_n == n0 && k < 200) begin
      tick();
      k++;
    end
    drv_valid = 1'b0;
    chk("accept_timeout", acc_n != n0, 1'b1);
    k = 0;
    while (q.size() > 0 && k < 200) begin
      tick();
      k++;
    end
    chk("seq_timeout", q.size() == 0, 1'b1);
    tick();
  endtask

  function automatic int n_writes();
    int n;
    n = 0;
    foreach (obs[i]) if (obs[i].wr) n++;
    return n;
  endfunction

  initial begin
    obs_t wl[$];
    int   e0, d0, k;

    #12;
    chk("rst_psel", m_psel, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_ovf", ovf_cnt, 8'h00);
    do_reset();

    // zero-wait command
    wait_fix = 0;
    obs.delete();
    run_cmd(8'h5A, 8'h03);
    chk("lat0", 8'(done_cyc - acc_cyc), RB ? 8'd11 : 8'd7);
    wl.delete();
    foreach (obs[i]) if (obs[i].wr) wl.push_back(obs[i]);
    chk("nwrites0", 8'(wl.size()), 8'd3);
    if (wl.size() == 3) begin
      chk("w0_addr", wl[0].addr, 8'h01);
      chk("w0_data", wl[0].data, 8'h5A);
      chk("w1_addr", wl[1].addr, 8'h00);
      chk("w1_data", wl[1].data, 8'h83);
      chk("w2_addr", wl[2].addr, 8'h00);
      chk("w2_data", wl[2].data, 8'h03);
    end

    // two wait states per transfer
    wait_fix = 2;
    run_cmd(8'h5A, 8'h03);
    chk("lat2", 8'(done_cyc - acc_cyc), RB ? 8'd21 : 8'd13);
    wait_fix = 0;

    // overflow pending blocks the command until service runs
    obs.delete();
    tsr_fix = 1;
    d0 = done_seen;
    drv_ovf = 1'b1;
    tick();
    drv_ovf = 1'b0;
    drv_valid = 1'b1;
    drv_tdr = 8'h5A;
    drv_tcr = 8'h03;
    tick();
    chk("ready_blocked", smp_ready, 1'b0);
    run_cmd(8'h5A, 8'h03);
    tsr_fix = -1;
    chk("svc_tsr", smp_tsr, 8'h01);
    chk("svc_done", 8'(done_seen - d0), 8'd1);
    if (obs.size() >= 3) begin
      chk("svc_rd", {obs[0].wr, obs[0].addr}, {1'b0, 8'h02});
      chk("svc_wr", {obs[1].wr, obs[1].addr}, {1'b1, 8'h02});
      chk("svc_clr", obs[1].data, 8'h00);
      chk("svc_then_cmd", obs[2].addr, 8'h01);
    end else begin
      chk("svc_obs_count", 8'(obs.size()), 8'd3);
    end

    // slave error on the load write aborts the command
    err_idx = RB ? 2 : 1;
    obs.delete();
    e0 = err_seen;
    d0 = done_seen;
    run_cmd(8'h5A, 8'h03);
    err_idx = -1;
    chk("slverr_err", 8'(err_seen - e0), 8'd1);
    chk("slverr_nodone", 8'(done_seen - d0), 8'd0);
    chk("slverr_writes", 8'(n_writes()), 8'd2);
    d0 = done_seen;
    run_cmd(8'h21, 8'h05);
    chk("after_err_done", 8'(done_seen - d0), 8'd1);

    // underflow counter saturation
    drv_urf = 1'b1;
    repeat (300) tick();
    drv_urf = 1'b0;
    k = 0;
    while ((q.size() > 0 || mdl_pend_u || mdl_pend_o) && k < 500) begin
      tick();
      k++;
    end
    tick();
    chk("udf_sat", smp_udf, 8'hFF);
    chk("udf_model", mdl_udf, 8'hFF);

`ifdef TIMER_SEQ_READBACK_EN
    rb_zero_tdr = 1'b1;
    obs.delete();
    e0 = err_seen;
    d0 = done_seen;
    run_cmd(8'h5A, 8'h03);
    rb_zero_tdr = 1'b0;
    chk("rb_err", 8'(err_seen - e0), 8'd1);
    chk("rb_nodone", 8'(done_seen - d0), 8'd0);
    chk("rb_writes", 8'(n_writes()), 8'd1);
`endif

    // randomized traffic
    do_reset();
    rnd = 1'b1;
    wait_fix = -1;
    wait_max = 2;
    err_pct = 5;
    rbm_pct = 8;
    evt_pct = 3;
    vld_pct = 40;
    repeat (4000) tick();

    // reset in the middle of an ACCESS phase
    rnd = 1'b0;
    drv_valid = 1'b0;
    wait_fix = 2;
    k = 0;
    while (q.size() > 0 && k < 200) begin
      tick();
      k++;
    end
    drv_ovf = 1'b1;
    tick();
    drv_ovf = 1'b0;
    drv_valid = 1'b1;
    k = 0;
    while (!(q.size() > 0 && q[0].penable) && k < 50) begin
      tick();
      k++;
    end
    drv_valid = 1'b0;
    #1;
    chk("pre_rst_psel", m_psel, 1'b1);
    #1;
    PRESET_n = 1'b0;
    #1;
    chk("mid_rst_psel", m_psel, 1'b0);
    chk("mid_rst_penable", m_penable, 1'b0);
    chk("mid_rst_ovf", ovf_cnt, 8'h00);
    chk("mid_rst_ready", cmd_ready, 1'b0);
    do_reset();
    tick();
    chk("ready_after_rst", smp_ready, 1'b1);

    rnd = 1'b1;
    wait_fix = -1;
    repeat (1500) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
